// File: rtl/cjb_stack_sequencer_v_pkg.sv
// Shared definitions for the stack sequencer: op codes, FSM states, helper functions.
package cjb_stack_sequencer_v_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUSH_S = 3'd1,
        POP_S  = 3'd2,
        CAPT   = 3'd3,
        REJ    = 3'd4,
        DONE   = 3'd5
    } state_e;

    // Bits needed to hold a depth of 0..depth inclusive.
    function automatic int unsigned depth_width(int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // POP and RET remove an entry; PUSH and CALL add one.
    function automatic logic is_pop(op_e o);
        return (o == OP_POP) || (o == OP_RET);
    endfunction

endpackage

// File: rtl/cjb_stack_depth_ctr_v.sv
// Saturating up/down depth counter with registered full/empty flags.
module cjb_stack_depth_ctr_v
    import cjb_stack_sequencer_v_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = depth_width(DEPTH)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] count_q, count_d;
    logic         full_q, empty_q;

    // Next count: saturate at both ends, simultaneous inc/dec cancels.
    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != W'(DEPTH))) begin
            count_d = count_q + W'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Count and flags update together so the flags always match the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/cjb_stack_sequencer_v.sv
// Control-side sequencer for the hardware stack: PUSH/POP/CALL/RET over req/done.
module cjb_stack_sequencer_v
    import cjb_stack_sequencer_v_pkg::*;
#(
    parameter int unsigned n     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req,
    input  logic [1:0]   op,
    input  logic [n-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [n-1:0] rdata,
    output logic         pc_load,
    output logic         full,
    output logic         empty,
    output logic         stk_push,
    output logic         stk_pop,
    output logic [n-1:0] stk_din,
    input  logic [n-1:0] stk_dout
);

    localparam int unsigned DW = depth_width(DEPTH);

    state_e       state_q, state_d;
    op_e          op_q, op_d;
    logic [n-1:0] data_q, data_d;
    logic [n-1:0] rdata_q;
    logic         busy_q, done_q, err_q, pc_load_q, push_q, pop_q;
    logic [DW-1:0] depth;

    cjb_stack_depth_ctr_v #(
        .DEPTH (DEPTH),
        .W     (DW)
    ) u_depth (
        .clock (clock),
        .reset (reset),
        .inc   (push_q),
        .dec   (pop_q),
        .count (depth),
        .full  (full),
        .empty (empty)
    );

    // Next state; op and data are latched only on the accept edge.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    op_d   = op_e'(op);
                    data_d = wdata;
                    if (is_pop(op_e'(op))) begin
                        state_d = (depth == '0) ? REJ : POP_S;
                    end else begin
                        state_d = (depth == DW'(DEPTH)) ? REJ : PUSH_S;
                    end
                end
            end
            PUSH_S:  state_d = DONE;
            POP_S:   state_d = CAPT;
            CAPT:    state_d = DONE;
            REJ:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State plus every output registered from the next state, so nothing is combinational
    // from req/op/wdata.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_PUSH;
            data_q    <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            pc_load_q <= 1'b0;
            push_q    <= 1'b0;
            pop_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            err_q     <= (state_d == DONE) && (state_q == REJ);
            pc_load_q <= (state_d == DONE) && (state_q == CAPT) && (op_q == OP_RET);
            push_q    <= (state_d == PUSH_S);
            pop_q     <= (state_d == POP_S);
            // Stack output is valid during CAPT, one edge after the pop strobe.
            if (state_q == CAPT) begin
                rdata_q <= stk_dout;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign pc_load  = pc_load_q;
    assign rdata    = rdata_q;
    assign stk_push = push_q;
    assign stk_pop  = pop_q;
    assign stk_din  = data_q;

endmodule

// File: tb/tb_cjb_stack_sequencer_v.sv
// Self-checking bench: sequencer plus a behavioural 4-entry stack, directed and random ops.
module tb_cjb_stack_sequencer_v;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req   = 1'b0;
    logic [1:0] op    = 2'b00;
    logic [7:0] wdata = 8'h00;
    logic       busy, done, err, pc_load, full, empty, stk_push, stk_pop;
    logic [7:0] rdata, stk_din, stk_dout;

    int compared   = 0;
    int mismatched = 0;

    // Reference: the stack contents as a queue (back = top) and the last popped value.
    logic [7:0] model_q[$];
    logic [7:0] model_rdata = 8'h00;

    cjb_stack_sequencer_v #(
        .n     (8),
        .DEPTH (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .op       (op),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .pc_load  (pc_load),
        .full     (full),
        .empty    (empty),
        .stk_push (stk_push),
        .stk_pop  (stk_pop),
        .stk_din  (stk_din),
        .stk_dout (stk_dout)
    );

    always #5 clock = ~clock;

    // 4-location stack primitive: push shifts down and drops the bottom, pop registers the top.
    logic [7:0] mem [4];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
            stk_dout <= 8'h00;
        end else if (stk_push) begin
            mem[0] <= stk_din;
            mem[1] <= mem[0];
            mem[2] <= mem[1];
            mem[3] <= mem[2];
        end else if (stk_pop) begin
            stk_dout <= mem[0];
            mem[0]   <= mem[1];
            mem[1]   <= mem[2];
            mem[2]   <= mem[3];
            mem[3]   <= 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, "_full"},  32'(full), 32'(model_q.size() == 4));
    endtask

    // Issue one op from IDLE (called at a negedge) and check latency, strobes and results.
    task automatic run_op(input logic [1:0] o, input logic [7:0] d, input string tag);
        bit         popish = (o == 2'b01) || (o == 2'b11);
        bit         rej;
        int         exp_lat, exp_push, exp_pop, done_at, pushes, pops;
        logic       exp_pc, got_err, got_pc;
        logic [7:0] exp_rd, got_rd;

        rej      = popish ? (model_q.size() == 0) : (model_q.size() == 4);
        exp_push = (!rej && !popish) ? 1 : 0;
        exp_pop  = (!rej && popish) ? 1 : 0;
        exp_lat  = exp_pop ? 3 : 2;
        exp_pc   = exp_pop && (o == 2'b11);
        if (exp_pop) model_rdata = model_q.pop_back();
        if (exp_push) model_q.push_back(d);
        exp_rd = model_rdata;

        check({tag, "_pre_busy"}, 32'(busy), 32'd0);
        req   = 1'b1;
        op    = o;
        wdata = d;
        @(posedge clock);
        @(negedge clock);
        req   = 1'b0;
        op    = 2'($urandom);
        wdata = 8'($urandom);

        done_at = 0; pushes = 0; pops = 0;
        got_err = 1'b0; got_pc = 1'b0; got_rd = 8'h00;
        for (int k = 1; k <= 6 && done_at == 0; k++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_strobe_overlap"}, 32'(stk_push & stk_pop), 32'd0);
            if (stk_push) begin
                pushes++;
                check({tag, "_stk_din"}, 32'(stk_din), 32'(d));
            end
            if (stk_pop) pops++;
            if (done) begin
                done_at = k;
                got_err = err;
                got_pc  = pc_load;
                got_rd  = rdata;
            end else begin
                check({tag, "_flags_outside_done"}, 32'({err, pc_load}), 32'd0);
                @(negedge clock);
            end
        end
        check({tag, "_latency"}, 32'(done_at), 32'(exp_lat));
        check({tag, "_err"},     32'(got_err), 32'(rej));
        check({tag, "_pc_load"}, 32'(got_pc),  32'(exp_pc));
        check({tag, "_rdata"},   32'(got_rd),  32'(exp_rd));
        check({tag, "_pushes"},  32'(pushes),  32'(exp_push));
        check({tag, "_pops"},    32'(pops),    32'(exp_pop));
        @(negedge clock);
        check_idle({tag, "_after"});
        check({tag, "_rdata_hold"}, 32'(rdata), 32'(model_rdata));
    endtask

    initial begin
        int pushes, dones;

        // Reset held two cycles.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_strobes", 32'({stk_push, stk_pop}), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single push then pop.
        run_op(2'b00, 8'hA5, "push_a5");
        run_op(2'b01, 8'h00, "pop_a5");

        // Fill, overflow, drain in LIFO order.
        run_op(2'b00, 8'h11, "fill_11");
        run_op(2'b00, 8'h22, "fill_22");
        run_op(2'b00, 8'h33, "fill_33");
        run_op(2'b00, 8'h44, "fill_44");
        run_op(2'b00, 8'h55, "overflow_55");
        run_op(2'b10, 8'h66, "overflow_call");
        run_op(2'b01, 8'h00, "drain_44");
        run_op(2'b01, 8'h00, "drain_33");
        run_op(2'b01, 8'h00, "drain_22");
        run_op(2'b01, 8'h00, "drain_11");

        // Underflow keeps rdata and depth.
        run_op(2'b01, 8'h00, "underflow_pop");
        run_op(2'b11, 8'h00, "underflow_ret");

        // CALL/RET loads the PC.
        run_op(2'b10, 8'h3C, "call_3c");
        run_op(2'b11, 8'h00, "ret_3c");

        // req held high: re-accepted only in IDLE, every third edge.
        req = 1'b1; op = 2'b00; wdata = 8'h77;
        pushes = 0; dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (stk_push) pushes++;
            if (done) dones++;
        end
        req = 1'b0;
        model_q.push_back(8'h77);
        model_q.push_back(8'h77);
        repeat (2) begin
            @(negedge clock);
            if (stk_push) pushes++;
            if (done) dones++;
        end
        check("held_req_pushes", 32'(pushes), 32'd2);
        check("held_req_dones",  32'(dones),  32'd2);
        check_idle("held_req");

        // Reset during POP_S: abort to IDLE, stack and depth cleared.
        req = 1'b1; op = 2'b01;
        @(posedge clock);
        @(negedge clock);
        req = 1'b0;
        check("midrst_pop_strobe", 32'(stk_pop), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        model_q.delete();
        model_rdata = 8'h00;
        check_idle("midrst");
        check("midrst_stk_pop", 32'(stk_pop), 32'd0);
        check("midrst_rdata",   32'(rdata), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        run_op(2'b01, 8'h00, "post_rst_pop");

        // Random op mix against the queue model.
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), 8'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
